// File: rtl/mc_controller_if.sv
// Purpose: signal bundle between the multicycle controller and its datapath/bench.
// Latency: none, plain wires; the controller drives all outputs combinationally.
// Backpressure: none, the controller advances one state per clock unconditionally.
// Ports: op/funct3/funct7b5 instruction fields; zero/notZero/LessThan/GreaterEqual ALU flags;
//        pcwrite/adrsrc/memwrite/irwrite/regwrite enables; resultsrc/alusrca/alusrcb/immsrc/alucontrol selects; state debug.
interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       notZero;
  logic       LessThan;
  logic       GreaterEqual;
  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  // master: instruction/flag source, control consumer (datapath or bench)
  modport master (
    output op, funct3, funct7b5, zero, notZero, LessThan, GreaterEqual,
    input  pcwrite, adrsrc, memwrite, irwrite, regwrite,
    input  resultsrc, alusrca, alusrcb, immsrc, alucontrol, state
  );

  // slave: the controller itself
  modport slave (
    input  op, funct3, funct7b5, zero, notZero, LessThan, GreaterEqual,
    output pcwrite, adrsrc, memwrite, irwrite, regwrite,
    output resultsrc, alusrca, alusrcb, immsrc, alucontrol, state
  );
endinterface

// File: rtl/mc_controller.sv
// Purpose: multicycle RISC-V control FSM (lw, sw, R-type, I-ALU, branch, jal).
// Latency: outputs are combinational from the current state; lw 5, sw/R/I/jal 4, branch 3, unknown op 2 cycles.
// Backpressure: none, one state step per clock; asynchronous reset forces FETCH immediately.
// Ports: clk, reset (async, active-high); bus = mc_controller_if.slave carrying all fields, flags and controls.
module mc_controller (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t r_state;

  logic       w_pcupdate;
  logic       w_branch;
  logic       w_taken;
  logic [1:0] w_aluop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECUTER;
            OP_I:         r_state <= S_EXECUTEI;
            OP_BR:        r_state <= S_BRANCH;
            OP_JAL:       r_state <= S_JAL;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: r_state <= S_FETCH;
        S_EXECUTER: r_state <= S_ALUWB;
        S_EXECUTEI: r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        default:    r_state <= S_FETCH;  // encodings 11-15 recover to FETCH
      endcase
    end
  end

  // Per-state control decode; encodings 11-15 fall to the all-zero default.
  always_comb begin
    w_pcupdate    = 1'b0;
    w_branch      = 1'b0;
    w_aluop       = 2'b00;
    bus.adrsrc    = 1'b0;
    bus.memwrite  = 1'b0;
    bus.irwrite   = 1'b0;
    bus.regwrite  = 1'b0;
    bus.resultsrc = 2'b00;
    bus.alusrca   = 2'b00;
    bus.alusrcb   = 2'b00;
    case (r_state)
      S_FETCH: begin
        bus.irwrite   = 1'b1;
        bus.alusrcb   = 2'b10;
        bus.resultsrc = 2'b10;
        w_pcupdate    = 1'b1;
      end
      S_DECODE: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b01;
      end
      S_MEMADR: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
      end
      S_MEMREAD:  bus.adrsrc = 1'b1;
      S_MEMWB: begin
        bus.resultsrc = 2'b01;
        bus.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adrsrc   = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_EXECUTER: begin
        bus.alusrca = 2'b10;
        w_aluop     = 2'b10;
      end
      S_EXECUTEI: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        w_aluop     = 2'b10;
      end
      S_ALUWB:    bus.regwrite = 1'b1;
      S_BRANCH: begin
        bus.alusrca = 2'b10;
        w_aluop     = 2'b01;
        w_branch    = 1'b1;
      end
      S_JAL: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b10;
        w_pcupdate  = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch condition; unsupported funct3 values simply do not branch.
  always_comb begin
    case (bus.funct3)
      3'b000:  w_taken = bus.zero;
      3'b001:  w_taken = bus.notZero;
      3'b100:  w_taken = bus.LessThan;
      3'b101:  w_taken = bus.GreaterEqual;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    bus.alucontrol = 3'b000;
    case (w_aluop)
      2'b01: bus.alucontrol = 3'b001;
      2'b10: begin
        case (bus.funct3)
          // sub only for R-type (op[5]=1) with bit 30 set; addi ignores bit 30
          3'b000:  bus.alucontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b111:  bus.alucontrol = 3'b010;
          3'b110:  bus.alucontrol = 3'b011;
          3'b001:  bus.alucontrol = 3'b100;
          3'b010:  bus.alucontrol = 3'b101;
          3'b101:  bus.alucontrol = 3'b110;
          3'b100:  bus.alucontrol = 3'b111;
          default: bus.alucontrol = 3'b000;
        endcase
      end
      default: bus.alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.immsrc = 2'b01;
      OP_BR:   bus.immsrc = 2'b10;
      OP_JAL:  bus.immsrc = 2'b11;
      default: bus.immsrc = 2'b00;
    endcase
  end

  assign bus.pcwrite = w_pcupdate | (w_branch & w_taken);
  assign bus.state   = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Purpose: directed self-checking bench for mc_controller against an instruction-level model.
// Latency: model expects lw 5, sw/R/I/jal 4, branch 3, unknown 2 cycles per instruction.
// Backpressure: none; stimulus advances just after each rising edge, checks run on the falling edge.
module tb_mc_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] UNK = 7'b1111111;

  localparam int P_STATE = 0;
  localparam int P_PCW   = 1;
  localparam int P_MW    = 2;
  localparam int P_REG   = 3;
  localparam int P_IMM   = 4;
  localparam int P_ALU   = 5;
  localparam int P_RES   = 6;
  localparam int P_IRW   = 7;

  typedef struct packed {
    logic       pcupd;
    logic       br;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // model context, written only by the stimulus process
  logic [3:0] exp_state = 4'd0;
  bit         mdl_on    = 1'b0;
  logic [6:0] cur_op    = 7'd0;
  logic [2:0] cur_f3    = 3'd0;
  logic       cur_f7    = 1'b0;
  logic [3:0] cur_fl    = 4'd0;  // {zero, notZero, LessThan, GreaterEqual}
  bit         pa_en = 1'b0, pb_en = 1'b0;
  int         pa_id = 0, pb_id = 0;
  logic [3:0] pa_exp = 4'd0, pb_exp = 4'd0;
  ctl_t       mc;

  // Number of cycles an instruction spends from FETCH until the next FETCH.
  function automatic int latency(input logic [6:0] o);
    case (o)
      LW:      return 5;
      SW, RT, IT, JAL: return 4;
      BR:      return 3;
      default: return 2;
    endcase
  endfunction

  // Which state the instruction occupies on its i-th cycle.
  function automatic logic [3:0] step_state(input logic [6:0] o, input int i);
    if (i == 0) return 4'd0;
    if (i == 1) return 4'd1;
    case (o)
      LW:      return (i == 2) ? 4'd2 : (i == 3) ? 4'd3 : 4'd4;
      SW:      return (i == 2) ? 4'd2 : 4'd5;
      RT:      return (i == 2) ? 4'd6 : 4'd8;
      IT:      return (i == 2) ? 4'd7 : 4'd8;
      BR:      return 4'd9;
      JAL:     return (i == 2) ? 4'd10 : 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic ctl_t ctl_of(input logic [3:0] s);
    ctl_t c;
    c = '0;
    case (s)
      4'd0:  begin c.irw = 1; c.sb = 2'b10; c.res = 2'b10; c.pcupd = 1; end
      4'd1:  begin c.sa = 2'b01; c.sb = 2'b01; end
      4'd2:  begin c.sa = 2'b10; c.sb = 2'b01; end
      4'd3:  c.adr = 1;
      4'd4:  begin c.res = 2'b01; c.rw = 1; end
      4'd5:  begin c.adr = 1; c.mw = 1; end
      4'd6:  c.sa = 2'b10;
      4'd7:  begin c.sa = 2'b10; c.sb = 2'b01; end
      4'd8:  c.rw = 1;
      4'd9:  begin c.sa = 2'b10; c.br = 1; end
      4'd10: begin c.sa = 2'b01; c.sb = 2'b10; c.pcupd = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic [3:0] fl);
    case (f3)
      3'b000:  return fl[3];
      3'b001:  return fl[2];
      3'b100:  return fl[1];
      3'b101:  return fl[0];
      default: return 1'b0;
    endcase
  endfunction

  // ALU op chosen by instruction meaning: address/PC math adds, compares subtract.
  function automatic logic [2:0] alu_of(input logic [3:0] s, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7);
    if (s == 4'd9) return 3'b001;
    if (s != 4'd6 && s != 4'd7) return 3'b000;
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b001:  return 3'b100;
      3'b010:  return 3'b101;
      3'b101:  return 3'b110;
      3'b100:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      SW:      return 2'b01;
      BR:      return 2'b10;
      JAL:     return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (state exp %0d, t=%0t)", name, act, exp, exp_state, $time);
    end
  endtask

  task automatic chk_pin(input int id, input logic [3:0] e);
    logic [3:0] a;
    case (id)
      P_STATE: a = bus.state;
      P_PCW:   a = {3'b0, bus.pcwrite};
      P_MW:    a = {3'b0, bus.memwrite};
      P_REG:   a = {3'b0, bus.regwrite};
      P_IMM:   a = {2'b0, bus.immsrc};
      P_ALU:   a = {1'b0, bus.alucontrol};
      P_RES:   a = {2'b0, bus.resultsrc};
      P_IRW:   a = {3'b0, bus.irwrite};
      default: a = 4'hx;
    endcase
    chk($sformatf("pin%0d", id), a, e);
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    if (mdl_on) begin
      mc = ctl_of(exp_state);
      chk("state",      bus.state,                exp_state);
      chk("pcwrite",    {3'b0, bus.pcwrite},      {3'b0, mc.pcupd | (mc.br & taken_of(cur_f3, cur_fl))});
      chk("adrsrc",     {3'b0, bus.adrsrc},       {3'b0, mc.adr});
      chk("memwrite",   {3'b0, bus.memwrite},     {3'b0, mc.mw});
      chk("irwrite",    {3'b0, bus.irwrite},      {3'b0, mc.irw});
      chk("regwrite",   {3'b0, bus.regwrite},     {3'b0, mc.rw});
      chk("resultsrc",  {2'b0, bus.resultsrc},    {2'b0, mc.res});
      chk("alusrca",    {2'b0, bus.alusrca},      {2'b0, mc.sa});
      chk("alusrcb",    {2'b0, bus.alusrcb},      {2'b0, mc.sb});
      chk("immsrc",     {2'b0, bus.immsrc},       {2'b0, imm_of(cur_op)});
      chk("alucontrol", {1'b0, bus.alucontrol},   {1'b0, alu_of(exp_state, cur_op, cur_f3, cur_f7)});
      if (pa_en) chk_pin(pa_id, pa_exp);
      if (pb_en) chk_pin(pb_id, pb_exp);
    end
  end

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [3:0] fl);
    cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_fl = fl;
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
    bus.zero = fl[3]; bus.notZero = fl[2]; bus.LessThan = fl[1]; bus.GreaterEqual = fl[0];
  endtask

  // Entered just after a rising edge with the DUT in FETCH; one literal pin on cycle pstep.
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [3:0] fl,
                     input int pstep, input int pid, input logic [3:0] pexp);
    drive(o, f3, f7, fl);
    for (int i = 0; i < latency(o); i++) begin
      exp_state = step_state(o, i);
      pa_en  = (i == pstep);
      pa_id  = pid;
      pa_exp = pexp;
      @(posedge clk); #1;
      pa_en = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(7'd0, 3'd0, 1'b0, 4'd0);
    exp_state = 4'd0;
    mdl_on = 1'b1;
    @(posedge clk); #1;
    // during reset: FETCH with PC/IR enables up
    pa_en = 1; pa_id = P_STATE; pa_exp = 4'd0;
    pb_en = 1; pb_id = P_PCW;   pb_exp = 4'd1;
    @(posedge clk); #1;
    pa_id = P_IRW; pa_exp = 4'd1;
    pb_id = P_MW;  pb_exp = 4'd0;
    @(posedge clk); #1;
    pa_en = 0; pb_en = 0;
    reset = 1'b0;

    run(LW,  3'b010, 1'b0, 4'b0000, 4, P_REG,   4'd1);
    run(LW,  3'b010, 1'b0, 4'b0000, 4, P_RES,   4'd1);
    run(SW,  3'b010, 1'b0, 4'b0000, 3, P_MW,    4'd1);
    run(SW,  3'b010, 1'b0, 4'b0000, 0, P_IMM,   4'd1);
    run(RT,  3'b000, 1'b1, 4'b0000, 2, P_ALU,   4'd1);
    run(IT,  3'b000, 1'b1, 4'b0000, 2, P_ALU,   4'd0);
    run(RT,  3'b111, 1'b0, 4'b0000, 2, P_ALU,   4'd2);
    run(RT,  3'b001, 1'b0, 4'b0000, 2, P_ALU,   4'd4);
    run(IT,  3'b101, 1'b0, 4'b0000, 2, P_ALU,   4'd6);
    run(RT,  3'b100, 1'b0, 4'b0000, 3, P_REG,   4'd1);
    run(BR,  3'b001, 1'b0, 4'b0100, 2, P_PCW,   4'd1);
    run(BR,  3'b001, 1'b0, 4'b1011, 2, P_PCW,   4'd0);
    run(BR,  3'b101, 1'b0, 4'b0001, 2, P_PCW,   4'd1);
    run(BR,  3'b010, 1'b0, 4'b1111, 2, P_PCW,   4'd0);
    run(BR,  3'b000, 1'b0, 4'b1000, 2, P_PCW,   4'd1);
    run(BR,  3'b100, 1'b0, 4'b1101, 2, P_PCW,   4'd0);
    run(BR,  3'b100, 1'b0, 4'b0010, 2, P_PCW,   4'd1);
    run(JAL, 3'b000, 1'b0, 4'b0000, 2, P_PCW,   4'd1);
    run(JAL, 3'b000, 1'b0, 4'b0000, 0, P_IMM,   4'd3);
    run(JAL, 3'b000, 1'b0, 4'b0000, 3, P_STATE, 4'd8);
    run(UNK, 3'b000, 1'b0, 4'b0000, 1, P_STATE, 4'd1);
    run(UNK, 3'b000, 1'b0, 4'b0000, 1, P_REG,   4'd0);

    // sw reaching MEMWRITE, then reset raised between edges
    drive(SW, 3'b010, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      exp_state = step_state(SW, i);
      @(posedge clk); #1;
    end
    exp_state = 4'd5;
    #2;
    reset = 1'b1;
    exp_state = 4'd0;
    pa_en = 1; pa_id = P_STATE; pa_exp = 4'd0;
    pb_en = 1; pb_id = P_MW;    pb_exp = 4'd0;
    @(posedge clk); #1;
    pa_en = 0; pb_en = 0;
    reset = 1'b0;

    run(LW,  3'b010, 1'b0, 4'b0000, 1, P_STATE, 4'd1);
    run(SW,  3'b010, 1'b0, 4'b0000, 3, P_STATE, 4'd5);

    mdl_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
